// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
//
// Purpose
//   Time-multiplexed scan controller for a four-digit seven-segment display.
//   A prescaler divides clk down to one "slot tick" every REFRESH_DIV cycles.
//   Each tick advances the active digit slot (0 = rightmost .. 3 = leftmost).
//   Four slots make one frame.
//
//   New values arrive over a valid/ready handshake. They land in a one-entry
//   pending buffer and are copied into the display register only at a frame
//   boundary. Because of that, a single frame never mixes digits from two
//   different values.
//
// Handshake
//   A transfer happens on a rising clk edge where in_valid && in_ready.
//   in_ready is simply !pend_full. It does not depend on in_valid in the same
//   cycle. Once pending is full, in_valid and in_data are ignored until the
//   next frame boundary drains the buffer. in_ready is high again on the cycle
//   after that boundary.
//
// Ports
//   clk            system clock, rising edge only
//   rst            synchronous active-high reset, dominates everything
//   in_data[15:0]  four BCD nibbles, [3:0] rightmost .. [15:12] leftmost
//   in_original    decimal-point flag that travels with in_data
//   in_valid       producer offers in_data / in_original
//   in_ready       pending buffer is empty and can take a value
//   refreshcounter active slot, drives the anode stage
//   digit_bcd      nibble for the active slot (registered, aligned with slot)
//   digit_blank    active slot must be dark
//   isOriginal     flag of the value currently on the display
//   frame_done     one-cycle pulse on the tick that ends slot 3
//
// Configuration
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits are blanked while
//                          running. The dot digit and everything to its right
//                          stay lit when isOriginal is set, so the display
//                          reads "0." rather than going dark. Slot 0 is never
//                          blanked.
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in_data,
    input  logic        in_original,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [1:0]  refreshcounter,
    output logic [3:0]  digit_bcd,
    output logic        digit_blank,
    output logic        isOriginal,
    output logic        frame_done
);

    // -------------------------------------------------------------------------
    // Configuration
    // -------------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    localparam int            PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

    // -------------------------------------------------------------------------
    // FSM encoding
    //   BLANK: nothing has been displayed since reset.
    //   RUN:   the display register holds a real value.
    // -------------------------------------------------------------------------
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    // -------------------------------------------------------------------------
    // Internal state
    // -------------------------------------------------------------------------
    logic [PW-1:0] prescaler;
    logic          pend_full;
    logic [15:0]   pend_data;
    logic          pend_orig;
    logic [15:0]   disp_data;
    logic          disp_orig;

    // Timing strobes
    logic          tick;
    logic          boundary;
    logic [1:0]    rc_next;

    // Handshake / buffer movement
    logic          accept;
    logic          load;

    // Next-cycle view of the display register
    logic [15:0]   disp_data_next;
    logic          disp_orig_next;

    // Next values of the registered outputs
    logic [3:0]    nib_next;
    logic [3:0]    bcd_d;
    logic          blank_d;
    logic          orig_d;

    // -------------------------------------------------------------------------
    // Strobes
    // -------------------------------------------------------------------------
    assign tick     = (prescaler == PRESC_MAX);
    assign boundary = tick && (refreshcounter == 2'd3);
    assign rc_next  = tick ? (refreshcounter + 2'd1) : refreshcounter;

    // accept and load are mutually exclusive. accept needs an empty buffer
    // and load needs a full one. If in_valid arrives on a boundary while the
    // buffer is empty, the value is simply accepted and waits for the next
    // frame.
    assign accept   = in_valid && !pend_full;
    assign load     = boundary && pend_full;

    assign in_ready   = !pend_full;
    assign frame_done = boundary;

    // -------------------------------------------------------------------------
    // Leading-zero blanking rule for one slot of a value.
    // A slot is blanked when it and every slot to its left are zero. When the
    // dot flag is set, only slot 3 may blank, so the dot digit stays lit.
    // -------------------------------------------------------------------------
    function automatic logic lz_blank(input logic [15:0] d,
                                      input logic [1:0]  slot,
                                      input logic        orig);
        logic z3;
        logic z2;
        logic z1;
        logic r;
        z3 = (d[15:12] == 4'd0);
        z2 = (d[11:8]  == 4'd0);
        z1 = (d[7:4]   == 4'd0);
        r  = 1'b0;
        case (slot)
            2'd3:    r = z3;
            2'd2:    r = z3 && z2 && !orig;
            2'd1:    r = z3 && z2 && z1 && !orig;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Prescaler and slot counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler      <= '0;
            refreshcounter <= 2'd0;
        end else begin
            if (tick) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PW'(1);
            end
            refreshcounter <= rc_next;
        end
    end

    // -------------------------------------------------------------------------
    // Pending buffer and display register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_full <= 1'b0;
            pend_data <= 16'd0;
            pend_orig <= 1'b0;
            disp_data <= 16'd0;
            disp_orig <= 1'b0;
        end else begin
            if (load) begin
                disp_data <= pend_data;
                disp_orig <= pend_orig;
                pend_full <= 1'b0;
            end
            if (accept) begin
                pend_full <= 1'b1;
                pend_data <= in_data;
                pend_orig <= in_original;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 1: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_BLANK;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM process 2: next-state logic
    // RUN is left only through reset.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_BLANK: if (load) state_next = ST_RUN;
            ST_RUN:   state_next = ST_RUN;
            default:  state_next = ST_BLANK;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM process 3: output logic
    // Outputs are computed from the *next* slot, display value and state, and
    // then registered. That way digit_bcd / digit_blank / isOriginal change on
    // the same edge as refreshcounter, with no skew between them.
    // -------------------------------------------------------------------------
    always_comb begin
        disp_data_next = load ? pend_data : disp_data;
        disp_orig_next = load ? pend_orig : disp_orig;

        nib_next = 4'd0;
        case (rc_next)
            2'd0:    nib_next = disp_data_next[3:0];
            2'd1:    nib_next = disp_data_next[7:4];
            2'd2:    nib_next = disp_data_next[11:8];
            default: nib_next = disp_data_next[15:12];
        endcase

        bcd_d   = 4'd0;
        blank_d = 1'b1;
        orig_d  = 1'b0;
        if (state_next == ST_RUN) begin
            // Nibbles above 9 pass straight through; decoding is downstream.
            bcd_d   = nib_next;
            blank_d = LZ_EN && lz_blank(disp_data_next, rc_next, disp_orig_next);
            orig_d  = disp_orig_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            digit_bcd   <= 4'd0;
            digit_blank <= 1'b1;
            isOriginal  <= 1'b0;
        end else begin
            digit_bcd   <= bcd_d;
            digit_blank <= blank_d;
            isOriginal  <= orig_d;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
//
// Testbench for display_scan_ctrl with REFRESH_DIV = 4.
// A behavioural model tracks the following:
//   - cycles since reset
//   - the pending entry
//   - the shown value
// On every falling edge, the model derives the slot, frame_done, in_ready and
// the digit outputs from plain arithmetic, and a compare process checks them.
// Directed sequences add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    localparam int DIV = 4;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic        in_original;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  refreshcounter;
    logic [3:0]  digit_bcd;
    logic        digit_blank;
    logic        isOriginal;
    logic        frame_done;

    int checks;
    int passes;

    display_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_original    (in_original),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .refreshcounter (refreshcounter),
        .digit_bcd      (digit_bcd),
        .digit_blank    (digit_blank),
        .isOriginal     (isOriginal),
        .frame_done     (frame_done)
    );

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Compare helper
    // -------------------------------------------------------------------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    int          t;
    logic        m_live;
    logic        m_pend;
    logic [15:0] m_pval;
    logic        m_porig;
    logic        m_shown;
    logic [15:0] m_disp;
    logic        m_dorig;

    initial begin
        m_live  = 1'b0;
        t       = 0;
        m_pend  = 1'b0;
        m_pval  = 16'd0;
        m_porig = 1'b0;
        m_shown = 1'b0;
        m_disp  = 16'd0;
        m_dorig = 1'b0;
    end

    function automatic logic model_blank(input logic [15:0] d, input int slot, input logic orig);
        logic en;
        logic lz;
`ifdef LEADING_ZERO_BLANK_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        // Blank when this slot and all to its left are zero; slot 0 never.
        // With the dot flag set, only the leftmost slot may go dark.
        lz = (slot != 0) && !(orig && slot != 3);
        for (int k = 0; k < 4; k++) begin
            if (k >= slot && ((d >> (4 * k)) & 16'hF) != 16'd0) lz = 1'b0;
        end
        return en && lz;
    endfunction

    always @(posedge clk) begin
        logic acc;
        logic bnd;
        if (rst) begin
            t       = 0;
            m_pend  = 1'b0;
            m_shown = 1'b0;
            m_disp  = 16'd0;
            m_dorig = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            bnd = (t % (4 * DIV)) == (4 * DIV - 1);
            acc = in_valid && !m_pend;
            if (bnd && m_pend) begin
                m_disp  = m_pval;
                m_dorig = m_porig;
                m_shown = 1'b1;
                m_pend  = 1'b0;
            end
            if (acc) begin
                m_pend  = 1'b1;
                m_pval  = in_data;
                m_porig = in_original;
            end
            t++;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        int slot;
        if (m_live) begin
            slot = (t / DIV) % 4;
            chk("model_rc", 16'(refreshcounter), 16'(slot));
            chk("model_frame_done", 16'(frame_done), 16'((t % (4 * DIV)) == (4 * DIV - 1)));
            chk("model_in_ready", 16'(in_ready), 16'(!m_pend));
            if (m_shown) begin
                chk("model_bcd", 16'(digit_bcd), (m_disp >> (4 * slot)) & 16'hF);
                chk("model_blank", 16'(digit_blank), 16'(model_blank(m_disp, slot, m_dorig)));
                chk("model_orig", 16'(isOriginal), 16'(m_dorig));
            end else begin
                chk("model_bcd_idle", 16'(digit_bcd), 16'd0);
                chk("model_blank_idle", 16'(digit_blank), 16'd1);
                chk("model_orig_idle", 16'(isOriginal), 16'd0);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic send(input logic [15:0] d, input logic o);
        int n;
        @(negedge clk);
        in_valid    = 1'b1;
        in_data     = d;
        in_original = o;
        n = 0;
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 16'(in_ready), 16'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 64);
        chk("frame_seen", 16'(frame_done), 16'd1);
    endtask

    // Walk one frame starting at slot 0, checking literal digits/blanks.
    task automatic check_frame(input string tag, input logic [15:0] digits,
                               input logic [3:0] blanks, input logic orig);
        for (int s = 0; s < 4; s++) begin
            chk({tag, "_rc"}, 16'(refreshcounter), 16'(s));
            chk({tag, "_bcd"}, 16'(digit_bcd), (digits >> (4 * s)) & 16'hF);
            chk({tag, "_blank"}, 16'(digit_blank), 16'(blanks[s]));
            chk({tag, "_orig"}, 16'(isOriginal), 16'(orig));
            repeat (DIV) @(negedge clk);
        end
    endtask

    // -------------------------------------------------------------------------
    // Directed stimulus
    // -------------------------------------------------------------------------
    logic [3:0] lz_42;
    logic [3:0] lz_05;
    int         pulses;

    initial begin
        checks      = 0;
        passes      = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 16'd0;
        in_original = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lz_42 = 4'b1100;
        lz_05 = 4'b1000;
`else
        lz_42 = 4'b0000;
        lz_05 = 4'b0000;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state, first cycle after reset
        chk("rst_rc", 16'(refreshcounter), 16'd0);
        chk("rst_bcd", 16'(digit_bcd), 16'd0);
        chk("rst_blank", 16'(digit_blank), 16'd1);
        chk("rst_orig", 16'(isOriginal), 16'd0);
        chk("rst_frame_done", 16'(frame_done), 16'd0);
        chk("rst_in_ready", 16'(in_ready), 16'd1);

        // Idle scan: slot steps every 4 clocks, frame pulse every 16
        pulses = 0;
        for (int i = 1; i <= 8; i++) begin
            repeat (DIV) begin
                @(negedge clk);
                if (frame_done) pulses++;
            end
            chk("idle_rc", 16'(refreshcounter), 16'(i % 4));
            chk("idle_blank", 16'(digit_blank), 16'd1);
        end
        chk("idle_pulses", 16'(pulses), 16'd2);

        // Single value: in_ready drops, then 4,3,2,1 from the next boundary
        send(16'h1234, 1'b0);
        chk("hs_ready_drop", 16'(in_ready), 16'd0);
        wait_frame();
        chk("pre_load_blank", 16'(digit_blank), 16'd1);
        @(negedge clk);
        chk("post_load_ready", 16'(in_ready), 16'd1);
        check_frame("v1234", 16'h1234, 4'b0000, 1'b0);

        // Back-to-back: 5678 waits for the boundary that shows 9876
        send(16'h9876, 1'b1);
        send(16'h5678, 1'b0);
        chk("hold_bcd", 16'(digit_bcd), 16'd6);
        chk("hold_orig", 16'(isOriginal), 16'd1);
        chk("hold_ready", 16'(in_ready), 16'd0);
        wait_frame();
        chk("pre_swap_bcd", 16'(digit_bcd), 16'd9);
        @(negedge clk);
        check_frame("v5678", 16'h5678, 4'b0000, 1'b0);

        // Leading-zero values
        send(16'h0042, 1'b0);
        wait_frame();
        @(negedge clk);
        check_frame("v0042", 16'h0042, lz_42, 1'b0);
        send(16'h0005, 1'b1);
        wait_frame();
        @(negedge clk);
        check_frame("v0005", 16'h0005, lz_05, 1'b1);

        // Reset mid-frame with a pending value and a live offer
        send(16'hABCD, 1'b0);
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h1111;
        rst      = 1'b1;
        @(negedge clk);
        chk("mid_rst_rc", 16'(refreshcounter), 16'd0);
        chk("mid_rst_bcd", 16'(digit_bcd), 16'd0);
        chk("mid_rst_blank", 16'(digit_blank), 16'd1);
        chk("mid_rst_orig", 16'(isOriginal), 16'd0);
        chk("mid_rst_frame_done", 16'(frame_done), 16'd0);
        chk("mid_rst_ready", 16'(in_ready), 16'd1);
        rst      = 1'b0;
        in_valid = 1'b0;
        wait_frame();
        @(negedge clk);
        chk("after_rst_blank", 16'(digit_blank), 16'd1);
        chk("after_rst_bcd", 16'(digit_bcd), 16'd0);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 clk  input  1  system clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_data  input  16  four BCD digits; [3:0] rightmost digit, [15:12] leftmost digit.
REQ-005 in_original  input  1  decimal-point flag travelling with in_data.
REQ-006 in_valid  input  1  producer offers in_data/in_original.
REQ-007 in_ready  output  1  block can accept a value into its pending buffer.
REQ-008 refreshcounter  output  2  active digit slot, 0 = rightmost, 3 = leftmost; drives the anode stage.
REQ-009 digit_bcd  output  4  BCD nibble for the active slot.
REQ-010 digit_blank  output  1  active slot SHALL be dark.
REQ-011 isOriginal  output  1  flag of the currently displayed value; drives the anode stage dot logic.
REQ-012 frame_done  output  1  one-cycle pulse at each frame boundary.

Function
REQ-013 The prescaler SHALL count 0..REFRESH_DIV-1 and then wrap; tick = (prescaler == REFRESH_DIV-1).
REQ-014 On tick, refreshcounter SHALL increment modulo 4, and 3 SHALL wrap to 0.
REQ-015 A frame boundary SHALL be defined as tick while refreshcounter == 3; frame_done SHALL be high for exactly that cycle.
REQ-016 Handshake: transfer occurs when in_valid && in_ready; in_ready = !pend_full; a transfer SHALL set pend_full and store in_data/in_original.
REQ-017 At a frame boundary with pend_full = 1, the pending value SHALL move into the display register and pend_full SHALL clear. in_ready SHALL rise on the following cycle.
REQ-018 The display register SHALL change only at frame boundaries, so no partial frame ever mixes two values.
REQ-019 The pending buffer SHALL be one entry deep. While pend_full = 1, in_valid SHALL be ignored and in_data may change freely.
REQ-020 If in_valid arrives at a boundary cycle with pend_full = 0, the value SHALL be accepted into pending and displayed from the next boundary.
REQ-021 FSM states: BLANK (no value displayed since reset) and RUN. BLANK -> RUN at the first boundary that loads the display register. RUN has no exit except rst.
REQ-022 In BLANK, digit_blank SHALL be 1, digit_bcd SHALL be 0, and isOriginal SHALL be 0.
REQ-023 In RUN, digit_bcd SHALL equal display nibble [4r+3:4r] with r = refreshcounter, updated in the same cycle as refreshcounter (registered, zero skew between the two).
REQ-024 Nibbles greater than 9 SHALL pass through unchanged; no error is flagged.
REQ-025 isOriginal SHALL be constant across a frame and SHALL update only with the display register.

Reset
REQ-026 rst SHALL dominate all other inputs in the same cycle. Any in-flight handshake, pending value and display value SHALL be discarded.
REQ-027 Reset values: prescaler 0, refreshcounter 0, digit_bcd 0, digit_blank 1, isOriginal 0, frame_done 0, pend_full 0 (so in_ready 1 on the first cycle after rst deasserts), FSM BLANK.

Configuration
REQ-028 Macro LEADING_ZERO_BLANK_EN: when defined, in RUN, slot 3 SHALL be blanked if its nibble is 0. Slot 2 SHALL be blanked if slots 3 and 2 are both 0. Slot 1 SHALL be blanked if slots 3, 2 and 1 are all 0.
REQ-029 With LEADING_ZERO_BLANK_EN defined and isOriginal = 1, slots 2..0 SHALL never be blanked, so the dot digit shows "0."; slot 0 SHALL never be blanked.
REQ-030 When LEADING_ZERO_BLANK_EN is undefined, digit_blank SHALL be 0 in every RUN slot.

Verification (REFRESH_DIV = 4)
REQ-031 rst for 2 cycles, then idle -> refreshcounter steps 0,1,2,3,0 every 4 clk; digit_blank = 1 throughout; frame_done pulses every 16 clk.
REQ-032 in_data 16'h1234, in_original 0, one valid cycle -> in_ready drops next cycle. From the next boundary, slots 0..3 show 4,3,2,1, digit_blank = 0, and in_ready returns to 1.
REQ-033 16'h1234 accepted, then 16'h5678 offered while pend_full = 1 -> 5678 is not accepted until the first boundary. It is then accepted, and 5678 shows only from the following boundary; no frame mixes digits.
REQ-034 With LEADING_ZERO_BLANK_EN, 16'h0042 and in_original 0 -> slots 3 and 2 are blank and slots 1 and 0 show 4 and 2. With 16'h0005 and in_original 1 -> slot 3 is blank, slots 2..0 show 0,0,5, and isOriginal = 1.
REQ-035 rst asserted mid-frame with pend_full = 1 -> the next cycle shows all reset values, in_ready = 1 and BLANK; the old pending value never appears.
